// File: rtl/arith_pkg.sv
// Shared arithmetic helpers for the pipelined adder family.
// Covers sizing functions and the parameter legality check used at elaboration.
package arith_pkg;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 1;
    end
    return result;
  endfunction

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Legal only when every stage gets an equal, non-empty chunk.
  function automatic bit width_ok(input int width, input int stages);
    return (stages >= 32'sd1) && (width >= stages) && ((width % stages) == 32'sd0);
  endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full adder cell; the building block of every ripple chunk.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple adder built from fa cells.
// Also exposes the carry into the MSB so the final stage can derive signed overflow.
module rca_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [W:0] c_s;

  assign c_s[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c_s[i]),
      .s  (s[i]),
      .co (c_s[i+1])
    );
  end

  assign co       = c_s[W];
  assign c_msb_in = c_s[W-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit ripple per stage, carry registered between stages.
// Operand skew shrinks and sum deskew grows stage by stage so the last stage holds an aligned result.
module pipelined_rca
  import arith_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH:0]   out
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!width_ok(WIDTH, STAGES)) begin : g_param_check
    $fatal(1, "pipelined_rca: WIDTH must be a non-zero multiple of STAGES");
  end

  logic en_s;

  // The whole pipe moves as one; only a held result at the output can stall it.
  assign en_s     = !out_valid || out_ready;
  assign in_ready = en_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM = WIDTH - k * CHUNK;
    localparam int SW  = (k + 1) * CHUNK;

    logic [REM-1:0]   a_s;
    logic [REM-1:0]   b_s;
    logic             ci_s;
    logic             v_in_s;
    logic [CHUNK-1:0] s_s;
    logic             co_s;
    logic             cm_s;
    logic [SW-1:0]    s_nx_s;
    logic [SW-1:0]    s_r;
    logic             v_r;
    logic             c_r;

    if (k == 0) begin : g_in
      assign a_s    = a;
      assign b_s    = sub ? ~b : b;
      assign ci_s   = sub ? 1'b1 : cin;
      assign v_in_s = in_valid;
      assign s_nx_s = s_s;
    end else begin : g_in
      assign a_s    = g_stage[k-1].g_skew.a_r;
      assign b_s    = g_stage[k-1].g_skew.b_r;
      assign ci_s   = g_stage[k-1].c_r;
      assign v_in_s = g_stage[k-1].v_r;
      assign s_nx_s = {s_s, g_stage[k-1].s_r};
    end

    rca_chunk #(.W(CHUNK)) u_chunk (
      .a        (a_s[CHUNK-1:0]),
      .b        (b_s[CHUNK-1:0]),
      .ci       (ci_s),
      .s        (s_s),
      .co       (co_s),
      .c_msb_in (cm_s)
    );

    // Valid follows en; data loads only behind a valid upstream beat so bubbles keep the last result.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        s_r <= {SW{1'b0}};
      end else if (en_s) begin
        v_r <= v_in_s;
        if (v_in_s) begin
          c_r <= co_s;
          s_r <= s_nx_s;
        end
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [REM-CHUNK-1:0] a_r;
      logic [REM-CHUNK-1:0] b_r;

      // Higher operand chunks wait here until their stage comes up.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_r <= {(REM-CHUNK){1'b0}};
          b_r <= {(REM-CHUNK){1'b0}};
        end else if (en_s && v_in_s) begin
          a_r <= a_s[REM-1:CHUNK];
          b_r <= b_s[REM-1:CHUNK];
        end
      end
    end

    if (k == STAGES - 1) begin : g_ovf
      logic ovf_r;

      // Signed overflow: carry into the MSB disagrees with carry out of it.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (en_s && v_in_s) begin
          ovf_r <= cm_s ^ co_s;
        end
      end
    end else begin : g_no_ovf
      logic unused_s;
      assign unused_s = cm_s;
    end
  end

  assign out_valid = g_stage[STAGES-1].v_r;
  assign sum       = g_stage[STAGES-1].s_r;
  assign cout      = g_stage[STAGES-1].c_r;
  assign ovf       = g_stage[STAGES-1].g_ovf.ovf_r;
  assign out       = {cout, sum};

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed self-checking bench for pipelined_rca at WIDTH=16, STAGES=4.
module tb_pipelined_rca;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              ovf;
  logic [WIDTH:0]    out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_rca #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .out       (out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: checks exact latency and every result field.
  task automatic run_one(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic sb, input logic [15:0] es,
                         input logic ec, input logic eo);
    a = av; b = bv; cin = ci; sub = sb;
    in_valid = 1'b1; out_ready = 1'b1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      chk({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
      step();
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sum"},   {16'd0, sum},       {16'd0, es});
    chk({tag, "_cout"},  {31'd0, cout},      {31'd0, ec});
    chk({tag, "_ovf"},   {31'd0, ovf},       {31'd0, eo});
    chk({tag, "_out"},   {15'd0, out},       {15'd0, ec, es});
    step();
  endtask

  int sent;
  int recv;
  int ocyc;
  int cyc;
  logic prev_stall;
  logic [15:0] prev_sum;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 16'h0000; b = 16'h0000;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum",       {16'd0, sum},       32'h0000_0000);
    chk("rst_cout",      {31'd0, cout},      32'd0);
    chk("rst_ovf",       {31'd0, ovf},       32'd0);
    rst = 1'b0;
    step();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out",       {15'd0, out},       32'h0000_0000);

    run_one("carry_chunk", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_one("full_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure stream: stall the output during its 3rd..5th valid cycles.
    sent = 0; recv = 0; ocyc = 0; cyc = 0;
    prev_stall = 1'b0; prev_sum = 16'h0000;
    cin = 1'b0; sub = 1'b0;
    while (recv < 8 && cyc < 60) begin
      in_valid = (sent < 8);
      a = 16'(sent + 1);
      b = 16'(32'h1000 * (sent + 1));
      if (out_valid) ocyc++;
      out_ready = !(ocyc >= 3 && ocyc <= 5);
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
      if (prev_stall) begin
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_sum",   {16'd0, sum},       {16'd0, prev_sum});
      end
      if (out_valid && out_ready) begin
        chk("bp_order", {16'd0, sum}, 32'h1001 * (recv + 1));
        recv++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", recv, 32'd8);
    for (int i = 0; i < 4; i++) begin
      chk("bp_drained", {31'd0, out_valid}, 32'd0);
      step();
    end

    // Reset with three beats in flight: none may surface afterwards.
    a = 16'h0011; b = 16'h0022; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1;
    step();
    step();
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("mid_rst_quiet", {31'd0, out_valid}, 32'd0);
      step();
    end
    run_one("post_rst", 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_rca.md
Name: pipelined_rca

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. It is the successor to the fixed 4-bit combinational ripple adder.
- The WIDTH-bit operand is split into STAGES equal chunks. Each chunk ripples in its own pipeline stage, with the carry registered between stages.
- A valid/ready handshake on both sides gives one result per cycle with backpressure.
- Used as the arithmetic datapath element in wider or higher-clock designs where a full-width ripple will not close timing.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and chunk count; CHUNK = WIDTH/STAGES bits per stage; STAGES>=1.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts operand beat this cycle.
- a  input  WIDTH  operand A (unsigned/two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: A+B+cin; 1: A-B (A+~B+1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry-out of MSB; in sub mode 1 = no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- out  output  WIDTH+1  {cout,sum}.

Behaviour:
- Reset (rst=1 at edge): all stage valid bits 0, all data/carry registers 0. Hence out_valid=0, sum=0, cout=0, ovf=0, out=0. in_ready=1 in the cycle after reset (pipeline empty). Reset mid-operation discards every in-flight beat; no stale result is ever emitted afterwards.
- Global advance enable: en = !out_valid | out_ready. in_ready = en (combinational from out_valid/out_ready only, never from in_valid).
- Input transfer when in_valid & in_ready. The operand beat is captured into stage 0 with B pre-inverted if sub=1 and carry-in = sub ? 1 : cin.
- Stage k (k=0..STAGES-1) adds chunk k: bits [k*CHUNK +: CHUNK] of A and B' plus the registered carry from stage k-1 (stage 0 uses the captured carry-in).
- Higher, not-yet-added operand chunks travel in skew registers. Already-computed lower sum chunks travel in deskew registers, so the final stage presents an aligned WIDTH-bit sum.
- Latency: exactly STAGES cycles from accepted beat to out_valid with no stall. Throughput: 1 beat/cycle.
- Stall: when en=0 every stage register, valid included, holds. No beat is dropped, duplicated or reordered.
- Bubble: a stage's valid bit advances with en; its data registers load only when en & upstream valid. sum/cout/ovf/out therefore hold the last delivered result while out_valid=0.
- ovf is computed in the final stage from the MSB carry-in and carry-out.
- Simultaneous in transfer and out transfer in the same cycle is normal streaming. Both occur; occupancy is unchanged.
- STAGES=1: pure registered adder, latency 1.

Decomposition:
- Shared package arith_pkg: function clog2, a CHUNK computation helper, and a WIDTH%STAGES==0 elaboration check. The check issues a fatal error on mismatch.
- One natural sub-module, rca_chunk: combinational CHUNK-bit ripple adder (a, b, ci -> s, co, c_msb_in), built from the existing FA full-adder cell. It is instantiated STAGES times via generate.
- Skew/deskew registers and the valid chain stay in pipelined_rca.

Test Plan (WIDTH=16, STAGES=4):
- Reset: rst=1 for 2 cycles, out_ready=1 -> out_valid=0, sum=0x0000, cout=0, ovf=0, in_ready=1 after release.
- Cross-chunk carry: a=0x00FF, b=0x0001, cin=0, sub=0 -> exactly 4 cycles later out_valid=1, sum=0x0100, cout=0, ovf=0, out=0x00100.
- Full ripple and overflow:
  - a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0.
  - a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure stream: 8 back-to-back beats a=i, b=0x1000*i (i=1..8), out_ready=0 on output cycles 3-5.
  - Expected: all 8 results a+b in order, none lost or duplicated.
  - in_ready=0 exactly while out_valid=1 & out_ready=0.
  - Outputs stable during the stall.
- Reset mid-flight: 3 beats accepted, rst=1 one cycle -> out_valid=0 next cycle and stays 0 until new beats arrive. The first post-reset beat 0x0002+0x0003 returns sum=0x0005 after 4 cycles.
